mem_arbiter: RTL and testbench

//  Shares one MEMCTRL memory port (CE/CSB/WEB/OEB/ADDR/IDATA/ODATA) between NREQ requesters.
//  Per-requester req/ack handshake; a granted access is one-cycle CE strobe, then idle/read wait.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 57 +++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the MEMCTRL port arbiter.
// Idle levels of the MEMCTRL strobes live here so every driver agrees on them.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int DEF_AW = 16;
   localparam int DEF_DW = 8;

   localparam logic CE_OFF  = 1'b0;
   localparam logic CSB_OFF = 1'b1;
   localparam logic WEB_OFF = 1'b1;
   localparam logic OEB_OFF = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: REQ plus last-grant pointer in, one-hot grant and index out.
// MEM_ARB_RR_EN selects round-robin; otherwise fixed priority, lowest index wins.
module mem_arb_pick #(
   parameter int NREQ = 2,
   parameter int IW   = 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IW-1:0]   o_idx,
   output logic            o_valid
);

`ifdef MEM_ARB_RR_EN
   int            w_cand;
   logic [IW-1:0] w_candIdx;

   // Search begins one past the last winner and wraps, so a waiting requester is served within NREQ-1 grants.
   always_comb begin
      o_grant   = '0;
      o_idx     = '0;
      o_valid   = 1'b0;
      w_cand    = 0;
      w_candIdx = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_cand = int'(i_ptr) + 1 + i;
         if (w_cand >= NREQ) begin
            w_cand = w_cand - NREQ;
         end
         w_candIdx = IW'(w_cand);
         if (!o_valid && i_req[w_candIdx]) begin
            o_valid            = 1'b1;
            o_idx              = w_candIdx;
            o_grant[w_candIdx] = 1'b1;
         end
      end
   end
`else
   logic w_unusedPtr;
   assign w_unusedPtr = ^i_ptr;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_valid    = 1'b1;
            o_idx      = IW'(i);
            o_grant    = '0;
            o_grant[i] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one MEMCTRL port between NREQ req/ack requesters; sole driver of the MEMCTRL strobes.
// Arbitration policy chosen in mem_arb_pick by MEM_ARB_RR_EN (round-robin when defined).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int AW     = DEF_AW,
   parameter int DW     = DEF_DW,
   parameter int RD_LAT = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   REQ,
   input  logic [NREQ-1:0]   REQ_WE,
   input  logic [NREQ*AW-1:0] REQ_ADDR,
   input  logic [NREQ*DW-1:0] REQ_WDATA,
   output logic [NREQ-1:0]   ACK,
   output logic [DW-1:0]     RDATA,
   output logic              CE,
   output logic              CSB,
   output logic              WEB,
   output logic              OEB,
   output logic [AW-1:0]     ADDR,
   output logic [DW-1:0]     IDATA,
   input  logic [DW-1:0]     ODATA
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(RD_LAT + 1);

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_winIdx;
   logic [NREQ-1:0] r_grant;
   logic            r_we;
   logic [CW-1:0]   r_cnt;

   logic [NREQ-1:0] w_pickGrant;
   logic [IW-1:0]   w_pickIdx;
   logic            w_pickValid;
   logic            w_accWe;
   logic [AW-1:0]   w_accAddr;
   logic [DW-1:0]   w_accWdata;

   mem_arb_pick #(
      .NREQ(NREQ),
      .IW  (IW)
   ) u_pick (
      .i_req  (REQ),
      .i_ptr  (r_ptr),
      .o_grant(w_pickGrant),
      .o_idx  (w_pickIdx),
      .o_valid(w_pickValid)
   );

   assign w_accWe    = REQ_WE[w_pickIdx];
   assign w_accAddr  = REQ_ADDR[w_pickIdx*AW +: AW];
   assign w_accWdata = REQ_WDATA[w_pickIdx*DW +: DW];

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_pickValid) w_next = ACCESS;
         ACCESS:  w_next = r_we ? DONE : WAIT;
         WAIT:    if (r_cnt == CW'(1)) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Strobes are registered: each edge sets the levels for the state being entered, so idle is the default.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state  <= IDLE;
         r_ptr    <= IW'(NREQ - 1);
         r_winIdx <= '0;
         r_grant  <= '0;
         r_we     <= 1'b0;
         r_cnt    <= '0;
         CE       <= CE_OFF;
         CSB      <= CSB_OFF;
         WEB      <= WEB_OFF;
         OEB      <= OEB_OFF;
         ADDR     <= '0;
         IDATA    <= '0;
         ACK      <= '0;
         RDATA    <= '0;
      end else begin
         r_state <= w_next;
         CE      <= CE_OFF;
         CSB     <= CSB_OFF;
         WEB     <= WEB_OFF;
         OEB     <= OEB_OFF;
         IDATA   <= '0;
         ACK     <= '0;
         case (r_state)
            IDLE: begin
               if (w_pickValid) begin
                  r_we     <= w_accWe;
                  r_winIdx <= w_pickIdx;
                  r_grant  <= w_pickGrant;
                  ADDR     <= w_accAddr;
                  CE       <= ~CE_OFF;
                  CSB      <= ~CSB_OFF;
                  if (w_accWe) begin
                     WEB   <= ~WEB_OFF;
                     IDATA <= w_accWdata;
                  end else begin
                     OEB <= ~OEB_OFF;
                  end
               end
            end
            ACCESS: begin
               if (r_we) begin
                  ACK <= r_grant;
               end else begin
                  OEB   <= ~OEB_OFF;
                  r_cnt <= CW'(RD_LAT);
               end
            end
            // ODATA is taken on the final WAIT edge, with ADDR and OEB still presenting the read.
            WAIT: begin
               if (r_cnt == CW'(1)) begin
                  RDATA <= ODATA;
                  ACK   <= r_grant;
               end else begin
                  OEB   <= ~OEB_OFF;
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            DONE: begin
               r_ptr <= r_winIdx;
            end
            default: begin
               r_ptr <= r_ptr;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small MEMCTRL behavioural model.
// Arbitration expectations follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_arbiter;

   localparam int NREQ   = 2;
   localparam int AW     = 16;
   localparam int DW     = 8;
   localparam int RD_LAT = 1;

   logic              CLK;
   logic              RST;
   logic [NREQ-1:0]   REQ;
   logic [NREQ-1:0]   REQ_WE;
   logic [NREQ*AW-1:0] REQ_ADDR;
   logic [NREQ*DW-1:0] REQ_WDATA;
   logic [NREQ-1:0]   ACK;
   logic [DW-1:0]     RDATA;
   logic              CE;
   logic              CSB;
   logic              WEB;
   logic              OEB;
   logic [AW-1:0]     ADDR;
   logic [DW-1:0]     IDATA;
   logic [DW-1:0]     ODATA;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int compared   = 0;
   int mismatched = 0;

   mem_arbiter #(
      .NREQ  (NREQ),
      .AW    (AW),
      .DW    (DW),
      .RD_LAT(RD_LAT)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .REQ      (REQ),
      .REQ_WE   (REQ_WE),
      .REQ_ADDR (REQ_ADDR),
      .REQ_WDATA(REQ_WDATA),
      .ACK      (ACK),
      .RDATA    (RDATA),
      .CE       (CE),
      .CSB      (CSB),
      .WEB      (WEB),
      .OEB      (OEB),
      .ADDR     (ADDR),
      .IDATA    (IDATA),
      .ODATA    (ODATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // MEMCTRL model: write on a CE edge with WEB low, read data driven only while OEB is low.
   always @(posedge CLK) begin
      if (CE && !CSB && !WEB) begin
         mem[ADDR] <= IDATA;
      end
   end
   assign ODATA = OEB ? '0 : mem[ADDR];

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [NREQ-1:0] we,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      REQ       = req;
      REQ_WE    = we;
      REQ_ADDR  = {a1, a0};
      REQ_WDATA = {d1, d0};
   endtask

   task automatic test_reset;
      RST = 1'b1;
      applyStimulus('0, '0, '0, '0, '0, '0);
      repeat (3) tick();
      compared++;
      if ({CE, CSB, WEB, OEB} !== 4'b0111) begin
         mismatched++;
         $display("[TB] FAIL reset_strobes: got %b expected %b", {CE, CSB, WEB, OEB}, 4'b0111);
      end
      compared++;
      if ({ADDR, IDATA} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_addr_idata: got %h expected 0", {ADDR, IDATA});
      end
      compared++;
      if ({ACK, RDATA} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_ack_rdata: got %h expected 0", {ACK, RDATA});
      end
      RST = 1'b0;
      tick();
   endtask

   task automatic test_write;
      applyStimulus(2'b01, 2'b01, 16'h0010, 16'h0000, 8'hA5, 8'h00);
      tick();
      compared++;
      if ({CE, CSB, WEB, OEB} !== 4'b1001) begin
         mismatched++;
         $display("[TB] FAIL write_strobes: got %b expected %b", {CE, CSB, WEB, OEB}, 4'b1001);
      end
      compared++;
      if ({ADDR, IDATA} !== {16'h0010, 8'hA5}) begin
         mismatched++;
         $display("[TB] FAIL write_addr_data: got %h expected %h", {ADDR, IDATA}, {16'h0010, 8'hA5});
      end
      compared++;
      if (ACK !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL write_early_ack: got %b expected 00", ACK);
      end
      tick();
      compared++;
      if ({ACK, CE, CSB, WEB, OEB, IDATA} !== {2'b01, 4'b0111, 8'h00}) begin
         mismatched++;
         $display("[TB] FAIL write_done: got %h expected %h", {ACK, CE, CSB, WEB, OEB, IDATA},
                  {2'b01, 4'b0111, 8'h00});
      end
      REQ = '0;
      tick();
      compared++;
      if (ACK !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL write_ack_pulse: got %b expected 00", ACK);
      end
   endtask

   task automatic test_read;
      applyStimulus(2'b10, 2'b00, 16'h0000, 16'h0010, 8'h00, 8'h00);
      tick();
      compared++;
      if ({CE, CSB, WEB, OEB, ADDR} !== {4'b1010, 16'h0010}) begin
         mismatched++;
         $display("[TB] FAIL read_access: got %h expected %h", {CE, CSB, WEB, OEB, ADDR}, {4'b1010, 16'h0010});
      end
      tick();
      compared++;
      if ({CE, CSB, WEB, OEB} !== 4'b0110) begin
         mismatched++;
         $display("[TB] FAIL read_wait_strobes: got %b expected %b", {CE, CSB, WEB, OEB}, 4'b0110);
      end
      compared++;
      if (ACK !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL read_early_ack: got %b expected 00", ACK);
      end
      tick();
      compared++;
      if ({ACK, RDATA} !== {2'b10, 8'hA5}) begin
         mismatched++;
         $display("[TB] FAIL read_done: got %h expected %h", {ACK, RDATA}, {2'b10, 8'hA5});
      end
      compared++;
      if ({CE, CSB, WEB, OEB} !== 4'b0111) begin
         mismatched++;
         $display("[TB] FAIL read_done_strobes: got %b expected %b", {CE, CSB, WEB, OEB}, 4'b0111);
      end
      REQ = '0;
      tick();
      compared++;
      if ({ACK, RDATA} !== {2'b00, 8'hA5}) begin
         mismatched++;
         $display("[TB] FAIL read_hold: got %h expected %h", {ACK, RDATA}, {2'b00, 8'hA5});
      end
   endtask

   task automatic test_arbitration;
      int              expGrant [4];
      logic [NREQ-1:0] expAck;
      int              waitCycles;
`ifdef MEM_ARB_RR_EN
      expGrant = '{0, 1, 0, 1};
`else
      expGrant = '{0, 0, 0, 0};
`endif
      applyStimulus(2'b11, 2'b11, 16'h0100, 16'h0200, 8'h11, 8'h22);
      for (int g = 0; g < 4; g++) begin
         waitCycles = 0;
         tick();
         while (ACK === '0 && waitCycles < 10) begin
            tick();
            waitCycles++;
         end
         expAck = NREQ'(1) << expGrant[g];
         compared++;
         if (ACK !== expAck) begin
            mismatched++;
            $display("[TB] FAIL arb_grant_%0d: got %b expected %b", g, ACK, expAck);
         end
         if (ACK !== '0) begin
            REQ = REQ & ~ACK;
            tick();
            REQ = 2'b11;
         end
      end
      REQ = '0;
      tick();
      tick();
   endtask

   task automatic test_reset_wait;
      applyStimulus(2'b01, 2'b01, 16'h0300, 16'h0000, 8'h33, 8'h00);
      tick();
      tick();
      compared++;
      if (ACK !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL rst_pre_write_ack: got %b expected 01", ACK);
      end
      REQ = '0;
      tick();
      applyStimulus(2'b01, 2'b00, 16'h0010, 16'h0000, 8'h00, 8'h00);
      tick();
      tick();
      RST = 1'b1;
      #1;
      compared++;
      if ({CE, CSB, WEB, OEB} !== 4'b0111) begin
         mismatched++;
         $display("[TB] FAIL rst_wait_strobes: got %b expected %b", {CE, CSB, WEB, OEB}, 4'b0111);
      end
      compared++;
      if ({ACK, RDATA} !== '0) begin
         mismatched++;
         $display("[TB] FAIL rst_wait_ack_rdata: got %h expected 0", {ACK, RDATA});
      end
      REQ = '0;
      for (int c = 0; c < 2; c++) begin
         tick();
         compared++;
         if (ACK !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL rst_no_ack_%0d: got %b expected 00", c, ACK);
         end
      end
      RST = 1'b0;
      applyStimulus(2'b11, 2'b11, 16'h0400, 16'h0500, 8'h44, 8'h55);
      tick();
      tick();
      compared++;
      if (ACK !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL rst_first_grant: got %b expected 01", ACK);
      end
      REQ = '0;
      tick();
   endtask

   task automatic test_boundary;
      applyStimulus(2'b10, 2'b10, 16'h0000, 16'hFFFF, 8'h00, 8'h5A);
      tick();
      compared++;
      if ({CE, CSB, WEB, OEB, ADDR, IDATA} !== {4'b1001, 16'hFFFF, 8'h5A}) begin
         mismatched++;
         $display("[TB] FAIL top_write_access: got %h expected %h", {CE, CSB, WEB, OEB, ADDR, IDATA},
                  {4'b1001, 16'hFFFF, 8'h5A});
      end
      tick();
      compared++;
      if (ACK !== 2'b10) begin
         mismatched++;
         $display("[TB] FAIL top_write_ack: got %b expected 10", ACK);
      end
      REQ = '0;
      tick();
      applyStimulus(2'b01, 2'b00, 16'hFFFF, 16'h0000, 8'h00, 8'h00);
      tick();
      compared++;
      if ({CE, CSB, WEB, OEB, ADDR} !== {4'b1010, 16'hFFFF}) begin
         mismatched++;
         $display("[TB] FAIL top_read_access: got %h expected %h", {CE, CSB, WEB, OEB, ADDR}, {4'b1010, 16'hFFFF});
      end
      applyStimulus(2'b00, 2'b01, 16'h1234, 16'h0000, 8'hEE, 8'h00);
      tick();
      compared++;
      if (ADDR !== 16'hFFFF) begin
         mismatched++;
         $display("[TB] FAIL top_read_addr_hold: got %h expected FFFF", ADDR);
      end
      tick();
      compared++;
      if ({ACK, RDATA} !== {2'b01, 8'h5A}) begin
         mismatched++;
         $display("[TB] FAIL top_read_done: got %h expected %h", {ACK, RDATA}, {2'b01, 8'h5A});
      end
      tick();
      compared++;
      if ({CE, ACK} !== 3'b000) begin
         mismatched++;
         $display("[TB] FAIL top_read_idle: got %b expected 000", {CE, ACK});
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_arbitration();
      test_reset_wait();
      test_boundary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
